// File: rtl/enemy_tank_driver.sv
// enemy_tank_driver: LFSR-driven wander/pause command source for an AI Tank (W/S/A/D keycode + fire strobe).
//   Optional feature macro: AI_CHASE_EN (steer picks toward the player when lfsr[6]==1).
//   Ports: frame_clk/Reset (async, active-high); enable parks the tank when low;
//   up/down/left/right clearance flags (1 = free); TankX/TankY/PlayerX/PlayerY positions
//   (chase only); keycode {8'h00,code}; Direction {dir,1'b0}; fire one-frame strobe;
//   state 00 IDLE / 01 PICK / 10 MOVE / 11 PAUSE.
module enemy_tank_driver #(
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [7:0]  MIN_HOLD     = 8'd8,
  parameter logic [7:0]  PAUSE_FRAMES = 8'd4,
  parameter logic [7:0]  FIRE_PERIOD  = 8'd32
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        enable,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic [9:0]  TankX,
  input  logic [9:0]  TankY,
  input  logic [9:0]  PlayerX,
  input  logic [9:0]  PlayerY,
  output logic [15:0] keycode,
  output logic [2:0]  Direction,
  output logic        fire,
  output logic [1:0]  state
);
  typedef enum logic [1:0] {IDLE = 2'b00, PICK = 2'b01, MOVE = 2'b10, PAUSE = 2'b11} state_t;
  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  state_t      state_q, state_d;
  logic [7:0]  code_q, code_d;
  logic [1:0]  dir_q, dir_d;
  logic        fire_q, fire_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  hold_q, hold_d, pause_q, pause_d, fire_cnt_q, fire_cnt_d;
  logic [3:0]  flags;
  logic [1:0]  cand, pick;
  logic        all_blocked;
  assign flags = {right, left, down, up};
  // Fibonacci x^16+x^14+x^13+x^11+1 in right-shift form (taps 0,2,3,5).
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
`ifdef AI_CHASE_EN
  logic signed [10:0] dx, dy;
  logic [10:0] adx, ady;
  logic [1:0]  toward;
  assign dx = $signed({1'b0, PlayerX}) - $signed({1'b0, TankX});
  assign dy = $signed({1'b0, PlayerY}) - $signed({1'b0, TankY});
  assign adx = dx[10] ? -dx : dx;
  assign ady = dy[10] ? -dy : dy;
  // Ties go vertical; coincident positions fall back to the random candidate.
  assign toward = (adx > ady) ? (dx[10] ? 2'd2 : 2'd3) : (dy[10] ? 2'd0 : 2'd1);
  assign cand = (lfsr_q[6] && (dx != 11'sd0 || dy != 11'sd0)) ? toward : lfsr_q[1:0];
`else
  logic unused_pos;
  assign unused_pos = ^{TankX, TankY, PlayerX, PlayerY};
  assign cand = lfsr_q[1:0];
`endif
  // First free heading starting at the candidate and rotating upward mod 4.
  assign pick = flags[cand] ? cand :
                flags[cand + 2'd1] ? cand + 2'd1 :
                flags[cand + 2'd2] ? cand + 2'd2 : cand + 2'd3;
  assign all_blocked = ~|flags;
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      code_q     <= 8'h00;
      dir_q      <= 2'd0;
      fire_q     <= 1'b0;
      lfsr_q     <= SEED;
      hold_q     <= 8'd0;
      pause_q    <= 8'd0;
      fire_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      dir_q      <= dir_d;
      fire_q     <= fire_d;
      lfsr_q     <= lfsr_d;
      hold_q     <= hold_d;
      pause_q    <= pause_d;
      fire_cnt_q <= fire_cnt_d;
    end
  end
  // A blocked heading re-steers before hold expiry is considered.
  always_comb begin
    state_d = !enable ? IDLE :
              state_q == IDLE ? PICK :
              state_q == PICK ? (all_blocked ? PAUSE : MOVE) :
              state_q == MOVE ? (!flags[dir_q] ? PICK : hold_q == 8'd1 ? PAUSE : MOVE) :
              (pause_q <= 8'd1 ? PICK : PAUSE);
  end
  // Registered outputs are computed for the state being entered.
  always_comb begin
    dir_d      = (enable && state_q == PICK && !all_blocked) ? pick : dir_q;
    hold_d     = state_q == PICK ? MIN_HOLD + {4'd0, lfsr_q[5:2]} :
                 state_q == MOVE ? hold_q - 8'd1 : hold_q;
    pause_d    = (state_d == PAUSE && state_q != PAUSE) ? PAUSE_FRAMES :
                 state_q == PAUSE ? pause_q - 8'd1 : pause_q;
    fire_d     = state_d == MOVE && FIRE_PERIOD != 8'd0 && fire_cnt_q == FIRE_PERIOD - 8'd1;
    fire_cnt_d = (state_d == IDLE || fire_d) ? 8'd0 :
                 state_d == MOVE ? fire_cnt_q + 8'd1 : fire_cnt_q;
    code_d     = state_d != MOVE ? 8'h00 :
                 dir_d == 2'd0 ? 8'h1a :
                 dir_d == 2'd1 ? 8'h16 :
                 dir_d == 2'd2 ? 8'h04 : 8'h07;
  end
  assign keycode   = {8'h00, code_q};
  assign Direction = {dir_q, 1'b0};
  assign fire      = fire_q;
  assign state     = state_q;
endmodule
